// File: rtl/boton_antirrebote_pulso.sv
// Push-button conditioner: polarity normalisation, 2-FF synchronizer,
// press/release debounce FSM, debounced level and one-clk press pulse.
module boton_antirrebote_pulso #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset_sw_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, pulse_n;
  logic             btn_in;
  logic [1:0]       sync_q;
  logic             btn_s;

  // Normalise polarity so that 1 always means "pressed" past this point.
  assign btn_in = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
  assign btn_s  = sync_q[1];

  // Two-flop synchronizer for the asynchronous pad; resets to "not pressed".
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge reset_sw_n) begin
    if (!reset_sw_n) sync_q <= 2'b00;
    else             sync_q <= {sync_q[0], btn_in};
  end

  // State, stability counter and registered outputs.
  always_ff @(posedge clk or negedge reset_sw_n) begin
    if (!reset_sw_n) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_level <= level_n;
      btn_pulse <= pulse_n;
    end
  end

  // Debounce decisions: a level change needs DEBOUNCE_CYCLES consecutive
  // agreeing samples; any disagreeing sample restarts the count.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = btn_level;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          pulse_n = 1'b1;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          level_n = 1'b0;
        end else begin
          cnt_n   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

endmodule
